// File: rtl/sm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sm_input_conditioner
// Description : Multi-channel conditioner for asynchronous board inputs.
//               Each channel is synchronised through a SYNC_STAGES-deep flop
//               chain and then debounced by a stability counter. The counter
//               must see `threshold` consecutive mismatching cycles before
//               the debounced level q follows the synchronised input. Each
//               transition of q raises a one-cycle rise or fall pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_input_conditioner #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_WIDTH   = 16,
    parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  d,
    input  logic [CNT_WIDTH-1:0] threshold,
    output logic [CHANNELS-1:0]  q,
    output logic [CHANNELS-1:0]  rise,
    output logic [CHANNELS-1:0]  fall,
    output logic                 changed
);

    // One extra bit on the comparison path so cnt+1 can never wrap.
    localparam logic [CNT_WIDTH:0] c_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic [CNT_WIDTH:0]  w_thr_eff;
    logic [CHANNELS-1:0] w_q;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;

    // A zero threshold behaves like one: a single mismatching cycle commits.
    always_comb begin
        w_thr_eff = {1'b0, threshold};
        if (threshold == '0) begin
            w_thr_eff = c_ONE;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_WIDTH-1:0]   r_cnt;
            logic                   r_q;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_s;
            logic [CNT_WIDTH:0]     w_cnt_inc;
            logic                   w_commit;

            // Synchronised sample is the last stage of the chain.
            assign w_s       = r_sync[SYNC_STAGES-1];
            assign w_cnt_inc = {1'b0, r_cnt} + c_ONE;
            assign w_commit  = (w_cnt_inc >= w_thr_eff);

            // Synchroniser chain: shift the raw input in, oldest sample at the top.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{RESET_VALUE[i]}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], d[i]};
                end
            end

            // Stability counter, debounced level and edge pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q    <= RESET_VALUE[i];
                    r_cnt  <= '0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else if (w_s == r_q) begin
                    // Agreement restarts the stability window.
                    r_cnt  <= '0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else if (w_commit) begin
                    r_q    <= w_s;
                    r_cnt  <= '0;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end else begin
                    // Cannot overflow: commit fires before cnt reaches 2^CNT_WIDTH-1.
                    r_cnt  <= w_cnt_inc[CNT_WIDTH-1:0];
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end
            end

            assign w_q[i]    = r_q;
            assign w_rise[i] = r_rise;
            assign w_fall[i] = r_fall;
        end
    endgenerate

    assign q       = w_q;
    assign rise    = w_rise;
    assign fall    = w_fall;
    assign changed = |(w_rise | w_fall);

endmodule
`default_nettype wire

// File: tb/tb_sm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_input_conditioner
// Description : Self-checking bench for sm_input_conditioner. A cycle model
//               pushes the expected outputs for every driven cycle into a
//               queue; each entry is popped and compared after the edge.
//               Directed checks cover the reset, latency, glitch, threshold
//               and reset-mid-count scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_input_conditioner;

    localparam int          c_CH  = 8;
    localparam int          c_CW  = 16;
    localparam logic [7:0]  c_RV  = 8'hA5;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_CH-1:0]   d;
    logic [c_CW-1:0]   threshold;
    logic [c_CH-1:0]   q;
    logic [c_CH-1:0]   rise;
    logic [c_CH-1:0]   fall;
    logic              changed;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Most recent sampled DUT outputs, for directed checks.
    logic [7:0] obs_q, obs_rise, obs_fall;
    logic       obs_changed;

    // Reference model state.
    logic [7:0] m_s0, m_s1, m_q;
    int         m_cnt[8];

    sm_input_conditioner #(
        .CHANNELS    (c_CH),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (c_CW),
        .RESET_VALUE (c_RV)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .threshold (threshold),
        .q         (q),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle model of the next edge given the currently driven inputs.
    task automatic model_step(output exp_t e);
        int thr_e;
        thr_e  = (threshold == 0) ? 1 : int'(threshold);
        e.rise = '0;
        e.fall = '0;
        if (rst) begin
            m_s0 = c_RV;
            m_s1 = c_RV;
            m_q  = c_RV;
            for (int ch = 0; ch < 8; ch++) m_cnt[ch] = 0;
        end else begin
            for (int ch = 0; ch < 8; ch++) begin
                if (m_s1[ch] == m_q[ch]) begin
                    m_cnt[ch] = 0;
                end else if (m_cnt[ch] + 1 >= thr_e) begin
                    m_q[ch]    = m_s1[ch];
                    m_cnt[ch]  = 0;
                    e.rise[ch] = m_s1[ch];
                    e.fall[ch] = ~m_s1[ch];
                end else begin
                    m_cnt[ch]++;
                end
            end
            m_s1 = m_s0;
            m_s0 = d;
        end
        e.q       = m_q;
        e.changed = |(e.rise | e.fall);
    endtask

    // One clock: predict, push, clock, sample, pop and compare.
    task automatic step();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q       = q;
        obs_rise    = rise;
        obs_fall    = fall;
        obs_changed = changed;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_q",       {24'd0, obs_q},    {24'd0, e.q});
            check("sb_rise",    {24'd0, obs_rise}, {24'd0, e.rise});
            check("sb_fall",    {24'd0, obs_fall}, {24'd0, e.fall});
            check("sb_changed", {31'd0, obs_changed}, {31'd0, e.changed});
        end
    endtask

    initial begin
        int r3, f3;
        logic [7:0] prev;
        m_s0 = '0; m_s1 = '0; m_q = '0;
        for (int ch = 0; ch < 8; ch++) m_cnt[ch] = 0;
        rst = 1'b1;
        d = 8'h00;
        threshold = 16'd4;

        // Reset held three cycles with d differing from RESET_VALUE.
        for (int i = 1; i <= 3; i++) step();
        check("rst_q",    {24'd0, obs_q},    32'h0000_00A5);
        check("rst_rise", {24'd0, obs_rise}, 32'd0);
        check("rst_fall", {24'd0, obs_fall}, 32'd0);
        check("rst_chg",  {31'd0, obs_changed}, 32'd0);

        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5) check("rel_q_e5", {24'd0, obs_q}, 32'h0000_00A5);
            if (i == 6) begin
                check("rel_q_e6",    {24'd0, obs_q},    32'h0000_0000);
                check("rel_fall_e6", {24'd0, obs_fall}, 32'h0000_00A5);
                check("rel_rise_e6", {24'd0, obs_rise}, 32'd0);
            end
            if (i == 7) check("rel_fall_e7", {24'd0, obs_fall}, 32'd0);
        end

        // Latency with threshold 4 on channel 0.
        d = 8'h01;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5) check("lat_q0_e5", {31'd0, obs_q[0]}, 32'd0);
            if (i == 6) begin
                check("lat_q0_e6",   {31'd0, obs_q[0]},    32'd1);
                check("lat_rise_e6", {24'd0, obs_rise},    32'h0000_0001);
                check("lat_chg_e6",  {31'd0, obs_changed}, 32'd1);
            end
            if (i == 7) begin
                check("lat_rise_e7", {24'd0, obs_rise},    32'd0);
                check("lat_chg_e7",  {31'd0, obs_changed}, 32'd0);
            end
        end

        // Glitch of 3 cycles on channel 3 is rejected.
        r3 = 0; f3 = 0;
        d = 8'h09;
        for (int i = 0; i < 3; i++) begin step(); r3 += obs_rise[3]; f3 += obs_fall[3]; end
        d = 8'h01;
        for (int i = 0; i < 10; i++) begin step(); r3 += obs_rise[3]; f3 += obs_fall[3]; end
        check("glitch3_q3",    {31'd0, obs_q[3]}, 32'd0);
        check("glitch3_rises", r3, 32'd0);
        check("glitch3_falls", f3, 32'd0);

        // A 4-cycle pulse passes: exactly one rise and one fall.
        d = 8'h09;
        for (int i = 0; i < 4; i++) begin step(); r3 += obs_rise[3]; f3 += obs_fall[3]; end
        d = 8'h01;
        for (int i = 0; i < 12; i++) begin step(); r3 += obs_rise[3]; f3 += obs_fall[3]; end
        check("pulse4_rises", r3, 32'd1);
        check("pulse4_falls", f3, 32'd1);
        check("pulse4_q3",    {31'd0, obs_q[3]}, 32'd0);

        // Threshold 0 and 1 both commit at edge 3.
        threshold = 16'd0;
        d = 8'h03;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 2) check("thr0_q1_e2", {31'd0, obs_q[1]}, 32'd0);
            if (i == 3) check("thr0_q1_e3", {31'd0, obs_q[1]}, 32'd1);
        end
        threshold = 16'd1;
        d = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 2) check("thr1_q1_e2", {31'd0, obs_q[1]}, 32'd1);
            if (i == 3) check("thr1_q1_e3", {31'd0, obs_q[1]}, 32'd0);
        end

        // Maximum threshold: commit at edge 65537, no wrap.
        threshold = 16'hFFFF;
        d = 8'h05;
        for (int i = 1; i <= 65538; i++) begin
            step();
            if (i == 65536) check("max_q2_e65536", {31'd0, obs_q[2]}, 32'd0);
            if (i == 65537) begin
                check("max_q2_e65537",    {31'd0, obs_q[2]},    32'd1);
                check("max_rise_e65537",  {24'd0, obs_rise},    32'h0000_0004);
            end
        end

        // Live threshold decrease commits on the next mismatching edge.
        threshold = 16'd100;
        d = 8'h15;
        for (int i = 0; i < 12; i++) step();
        check("live_q4_before", {31'd0, obs_q[4]}, 32'd0);
        threshold = 16'd5;
        step();
        check("live_q4_after",  {31'd0, obs_q[4]}, 32'd1);
        check("live_rise",      {24'd0, obs_rise}, 32'h0000_0010);

        // Simultaneous transitions on channels 0 and 7.
        threshold = 16'd2;
        prev = d;
        d = d ^ 8'h81;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 3) check("simul_chg_e3", {31'd0, obs_changed}, 32'd0);
            if (i == 4) begin
                check("simul_rise", {24'd0, obs_rise}, {24'd0, ~prev & 8'h81});
                check("simul_fall", {24'd0, obs_fall}, {24'd0,  prev & 8'h81});
                check("simul_chg",  {31'd0, obs_changed}, 32'd1);
            end
        end

        // Reset mid-count discards the count.
        threshold = 16'd8;
        d = 8'h5A;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        check("rmid_q",    {24'd0, obs_q},    32'h0000_00A5);
        check("rmid_rise", {24'd0, obs_rise}, 32'd0);
        check("rmid_fall", {24'd0, obs_fall}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 9) check("rmid_q_e9", {24'd0, obs_q}, 32'h0000_00A5);
            if (i == 10) begin
                check("rmid_q_e10",    {24'd0, obs_q},    32'h0000_005A);
                check("rmid_rise_e10", {24'd0, obs_rise}, 32'h0000_005A);
                check("rmid_fall_e10", {24'd0, obs_fall}, 32'h0000_00A5);
            end
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            threshold = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
